// File: rtl/bias_mult_scheduler.sv
// bias_mult_scheduler: round-robin arbiter that shares one pipelined WIDTHxWIDTH
// bias multiplier among NREQ requesters and returns the product tagged by id.
// Build option: define BIAS_MULT_SAT_EN to saturate results whose product
// overflows WIDTH bits; when undefined the low WIDTH bits are returned.
//
// state | meaning
// IDLE  | ready for a new request, gnt driven from the round-robin search
// BUSY  | operands latched, down-counter waiting out the multiplier latency
// RESP  | out_valid high, result held until out_ready
module bias_mult_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int IDW   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*WIDTH-1:0]   i_in_bus,
  input  logic [NREQ*WIDTH-1:0]   i_bias_bus,
  input  logic                    i_out_ready,
  output logic [NREQ-1:0]         o_gnt,
  output logic                    o_ready,
  output logic                    o_out_valid,
  output logic [IDW-1:0]          o_out_id,
  output logic [WIDTH-1:0]        o_out_data
);

`ifdef BIAS_MULT_SAT_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_out_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out_data;
  logic             w_found;
  logic [IDW-1:0]   w_sel;
  logic [IDW:0]     w_idx;
  logic             w_issue;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_tap;
  logic [WIDTH-1:0] w_result;

  // Round-robin search: first requester after r_rr_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      if (!w_found && i_req[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_issue = (r_state == S_IDLE) && w_found;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and Moore outputs; gnt follows req combinationally in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    o_gnt       = '0;
    o_ready     = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (w_found) begin
          o_gnt       = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: if (r_cnt == 3'd0) w_state_nxt = S_RESP;
      S_RESP: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latency down-counter; RESP is entered on terminal count zero.
  always_ff @(posedge i_clk) begin
    if (i_reset)                           r_cnt <= 3'd0;
    else if (w_issue)                      r_cnt <= 3'(LAT - 1);
    else if (r_state == S_BUSY && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
  end

  // Without saturation only the low WIDTH product bits are ever formed.
  assign w_prod = PW'(r_a) * PW'(r_b);

  generate
    if (LAT == 1) begin : g_comb
      assign w_tap = w_prod;
    end else begin : g_pipe
      logic [PW-1:0] r_pipe [LAT-1];
      // Free-running multiplier pipeline; the tap lines up with cnt==0.
      always_ff @(posedge i_clk) begin
        r_pipe[0] <= w_prod;
        for (int k = 1; k < LAT - 1; k++) r_pipe[k] <= r_pipe[k-1];
      end
      assign w_tap = r_pipe[LAT-2];
    end
  endgenerate

`ifdef BIAS_MULT_SAT_EN
  assign w_result = (w_tap[PW-1:WIDTH] != '0) ? {WIDTH{1'b1}} : w_tap[WIDTH-1:0];
`else
  assign w_result = w_tap;
`endif

  // Grant bookkeeping and result capture; outputs change only on RESP entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr   <= IDW'(NREQ - 1);
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_out_id   <= '0;
      r_out_data <= '0;
    end else begin
      if (w_issue) begin
        r_rr_ptr <= w_sel;
        r_id     <= w_sel;
        r_a      <= i_in_bus[w_sel*WIDTH +: WIDTH];
        r_b      <= i_bias_bus[w_sel*WIDTH +: WIDTH];
      end
      if (r_state == S_BUSY && r_cnt == 3'd0) begin
        r_out_id   <= r_id;
        r_out_data <= w_result;
      end
    end
  end

  assign o_out_id   = r_out_id;
  assign o_out_data = r_out_data;

endmodule

// File: tb/tb_bias_mult_scheduler.sv
// Testbench for bias_mult_scheduler: vector table, corner-case sequences and
// a randomized run against a transaction-level reference model.
module tb_bias_mult_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LAT   = 2;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] in_bus = '0;
  logic [NREQ*WIDTH-1:0] bias_bus = '0;
  logic                  out_ready = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic                  ready;
  logic                  out_valid;
  logic [IDW-1:0]        out_id;
  logic [WIDTH-1:0]      out_data;

  int checks = 0;
  int errors = 0;

  bias_mult_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .IDW(IDW)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_in_bus(in_bus),
    .i_bias_bus(bias_bus), .i_out_ready(out_ready), .o_gnt(gnt),
    .o_ready(ready), .o_out_valid(out_valid), .o_out_id(out_id),
    .o_out_data(out_data));

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] req;
    int a;
    int b;
    logic [NREQ-1:0] gnt;
    int id;
    int wrap;
    int sat;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_ops(input int a, input int b);
    for (int i = 0; i < NREQ; i++) begin
      in_bus[i*WIDTH +: WIDTH]   = WIDTH'(a);
      bias_bus[i*WIDTH +: WIDTH] = WIDTH'(b);
    end
  endtask

  function automatic int expect_data(input int a, input int b);
    int p;
    p = a * b;
`ifdef BIAS_MULT_SAT_EN
    return (p >= (1 << WIDTH)) ? (1 << WIDTH) - 1 : p;
`else
    return p % (1 << WIDTH);
`endif
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // model / scratch state
  int gidx [8];
  int gcyc [8];
  int ng, nvalid, ngnt, seen;
  int m_rr, m_id, m_data, m_resp_cycle, m_sel;
  bit m_idle, m_resp;
  logic [NREQ-1:0] pend, exp_gnt;
  int la [NREQ];
  int lb [NREQ];

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'b0001,   3,   5, 4'b0001, 0,  15,  15};
    vecs[1] = '{4'b1111,  20,  20, 4'b0010, 1, 144, 255};
    vecs[2] = '{4'b1001, 255, 255, 4'b1000, 3,   1, 255};
    vecs[3] = '{4'b0110,   0, 200, 4'b0010, 1,   0,   0};
    vecs[4] = '{4'b0101,  16,  16, 4'b0100, 2,   0, 255};
    vecs[5] = '{4'b0011,  15,  17, 4'b0001, 0, 255, 255};

    do_reset();
    @(negedge clk);
    chk("reset_ready", 32'(ready), 1);
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_id", 32'(out_id), 0);
    chk("reset_data", 32'(out_data), 0);
    tick();

    // table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      req = vecs[v].req;
      set_ops(vecs[v].a, vecs[v].b);
      @(negedge clk);
      chk("vec_gnt", 32'(gnt), 32'(vecs[v].gnt));
      chk("vec_ready", 32'(ready), 1);
      tick();
      req = '0;
      set_ops(99, 99);
      for (int c = 1; c <= LAT; c++) begin
        @(negedge clk);
        chk("vec_busy_valid", 32'(out_valid), 0);
        tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_id", 32'(out_id), 32'(vecs[v].id));
`ifdef BIAS_MULT_SAT_EN
      chk("vec_data", 32'(out_data), 32'(vecs[v].sat));
`else
      chk("vec_data", 32'(out_data), 32'(vecs[v].wrap));
`endif
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      chk("vec_ready_after", 32'(ready), 1);
      chk("vec_data_kept", 32'(out_data), 32'(expect_data(vecs[v].a, vecs[v].b)));
      tick();
    end

    // round-robin with all requesters held
    do_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    set_ops(1, 1);
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt != '0 && ng < 8) begin
        gidx[ng] = oh2i(gnt);
        gcyc[ng] = c;
        ng++;
      end
      tick();
    end
    chk("rr_count_ge5", 32'(ng >= 5), 1);
    if (ng >= 5) begin
      chk("rr_first_cycle", 32'(gcyc[0]), 0);
      for (int g = 0; g < 5; g++) chk("rr_order", 32'(gidx[g]), 32'(g % NREQ));
      for (int g = 1; g < 5; g++) chk("rr_interval", 32'(gcyc[g] - gcyc[g-1]), 32'(LAT + 2));
    end

    // backpressure in RESP with requests pending
    do_reset();
    req = 4'b0001;
    set_ops(7, 9);
    @(negedge clk);
    chk("bp_gnt0", 32'(gnt), 32'(4'b0001));
    tick();
    req = 4'b1110;
    out_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else tick();
    end
    chk("bp_valid_seen", 32'(seen), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_id", 32'(out_id), 0);
      chk("bp_hold_data", 32'(out_data), 63);
      chk("bp_no_gnt", 32'(gnt), 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", 32'(out_valid), 1);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_gnt", 32'(gnt), 32'(4'b0010));
    tick();

    // reset while BUSY aborts the operation and restores priority
    do_reset();
    req = 4'b0001;
    set_ops(3, 3);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(4'b0001));
    tick();
    req = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(ready), 1);
    req = 4'b1000;
    #1;
    chk("rst_gnt3", 32'(gnt), 32'(4'b1000));
    tick();
    req = '0;
    out_ready = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        nvalid++;
        chk("rst_new_id", 32'(out_id), 3);
      end
      tick();
    end
    chk("rst_one_result", 32'(nvalid), 1);

    // requester 2 pulses only while requester 1 is in flight
    do_reset();
    req = 4'b0010;
    set_ops(4, 6);
    @(negedge clk);
    chk("drop_gnt1", 32'(gnt), 32'(4'b0010));
    tick();
    req = 4'b0100;
    tick();
    req = '0;
    out_ready = 1'b1;
    nvalid = 0;
    ngnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt != '0) ngnt++;
      if (out_valid) begin
        nvalid++;
        chk("drop_id", 32'(out_id), 1);
        chk("drop_data", 32'(out_data), 24);
      end
      tick();
    end
    chk("drop_no_gnt", 32'(ngnt), 0);
    chk("drop_one_valid", 32'(nvalid), 1);

    // randomized run against a transaction-level model
    do_reset();
    m_rr = NREQ - 1;
    m_idle = 1'b1;
    m_resp = 1'b0;
    m_resp_cycle = -1;
    m_id = 0;
    m_data = 0;
    pend = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 4) == 0) pend[i] = 1'b1;
        else if (pend[i] && ($urandom % 32) == 0) pend[i] = 1'b0;
        la[i] = (($urandom % 4) == 0) ? 255 : int'($urandom % 256);
        lb[i] = int'($urandom % 256);
        in_bus[i*WIDTH +: WIDTH]   = WIDTH'(la[i]);
        bias_bus[i*WIDTH +: WIDTH] = WIDTH'(lb[i]);
      end
      req = pend;
      out_ready = ($urandom % 3) != 0;

      exp_gnt = '0;
      m_sel = -1;
      if (m_idle) begin
        for (int k = 1; k <= NREQ && m_sel < 0; k++)
          if (req[(m_rr + k) % NREQ]) m_sel = (m_rr + k) % NREQ;
        if (m_sel >= 0) exp_gnt[m_sel] = 1'b1;
      end

      @(negedge clk);
      chk("rnd_gnt", 32'(gnt), 32'(exp_gnt));
      chk("rnd_ready", 32'(ready), 32'(m_idle));
      chk("rnd_valid", 32'(out_valid), 32'(m_resp));
      if (m_resp) begin
        chk("rnd_id", 32'(out_id), 32'(m_id));
        chk("rnd_data", 32'(out_data), 32'(m_data));
      end

      if (m_sel >= 0) begin
        m_rr = m_sel;
        m_id = m_sel;
        m_data = expect_data(la[m_sel], lb[m_sel]);
        m_idle = 1'b0;
        m_resp_cycle = cyc + LAT + 1;
        pend[m_sel] = 1'b0;
      end else if (m_resp && out_ready) begin
        m_resp = 1'b0;
        m_idle = 1'b1;
      end else if (!m_idle && !m_resp && cyc + 1 == m_resp_cycle) begin
        m_resp = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
